// File: rtl/snake_body_engine.sv
// Snake-body engine: holds the ordered segment coordinates, moves or grows the snake on
// request with a one-segment-per-cycle collision scan, and drives the flattened LED map.
module snake_body_engine #(
  parameter int GRID_W   = 6,
  parameter int GRID_H   = 6,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 2,
  parameter int WRAP     = 0,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int NC = GRID_W * GRID_H
) (
  input  logic          clock,
  input  logic          restart,
  input  logic          init,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  output logic          busy,
  output logic          done,
  output logic          ate,
  output logic          collided,
  output logic          full,
  output logic [LW-1:0] size,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [NC-1:0] leds,
  output logic [2:0]    db_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEAD   = 3'd1,
    S_SCAN   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] DIR_UP = 2'd0, DIR_RIGHT = 2'd1, DIR_DOWN = 2'd2, DIR_LEFT = 2'd3;
  localparam logic [YW-1:0] INIT_Y = YW'(GRID_H / 2);

  function automatic logic [XW-1:0] init_x(input int i);
    return (i < INIT_LEN) ? XW'(INIT_LEN - 1 - i) : '0;
  endfunction

  state_t        state_q, state_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [LW-1:0] size_q, size_d, n_q, n_d, idx_q, idx_d;
  logic [1:0]    last_dir_q, last_dir_d, dir_q, dir_d;
  logic [XW-1:0] cand_x_q, cand_x_d;
  logic [YW-1:0] cand_y_q, cand_y_d;
  logic          eat_q, eat_d, ate_q, ate_d, collided_q, collided_d, full_q, full_d;

  logic [1:0]    eff_dir;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          wall, hit, eat_now;

  // NOTE: the segment store is reset because the initial body position is architectural
  // state, not don't-care contents; sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= INIT_Y;
      end
      size_q     <= LW'(INIT_LEN);
      n_q        <= '0;
      idx_q      <= '0;
      last_dir_q <= DIR_RIGHT;
      dir_q      <= DIR_RIGHT;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      eat_q      <= 1'b0;
      ate_q      <= 1'b0;
      collided_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
      size_q     <= size_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      last_dir_q <= last_dir_d;
      dir_q      <= dir_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      eat_q      <= eat_d;
      ate_q      <= ate_d;
      collided_q <= collided_d;
      full_q     <= full_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;   seg_x_d = seg_x_q;   seg_y_d = seg_y_q;
    size_d = size_q;     n_d = n_q;           idx_d = idx_q;
    last_dir_d = last_dir_q;  dir_d = dir_q;
    cand_x_d = cand_x_q; cand_y_d = cand_y_q; eat_d = eat_q;
    ate_d = ate_q;       collided_d = collided_q;  full_d = full_q;
    nx = seg_x_q[0];     ny = seg_y_q[0];     wall = 1'b0;  hit = 1'b0;  eat_now = 1'b0;

    // A reversal onto the neck is replaced by continuing straight.
    eff_dir = (size_q > LW'(1) && dir_q == (last_dir_q ^ 2'b10)) ? last_dir_q : dir_q;
    case (eff_dir)
      DIR_UP: begin
        wall = (seg_y_q[0] == '0);
        ny   = wall ? YW'(GRID_H - 1) : seg_y_q[0] - YW'(1);
      end
      DIR_RIGHT: begin
        wall = (seg_x_q[0] == XW'(GRID_W - 1));
        nx   = wall ? '0 : seg_x_q[0] + XW'(1);
      end
      DIR_DOWN: begin
        wall = (seg_y_q[0] == YW'(GRID_H - 1));
        ny   = wall ? '0 : seg_y_q[0] + YW'(1);
      end
      default: begin
        wall = (seg_x_q[0] == '0);
        nx   = wall ? XW'(GRID_W - 1) : seg_x_q[0] - XW'(1);
      end
    endcase

    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) == idx_q && seg_x_q[i] == cand_x_q && seg_y_q[i] == cand_y_q) hit = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (step && !collided_q && !full_q) begin
          dir_d   = dir;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        dir_d = eff_dir;
        if (wall && WRAP == 0) begin
          collided_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          eat_now  = (nx == apple_x) && (ny == apple_y);
          cand_x_d = nx;
          cand_y_d = ny;
          eat_d    = eat_now;
          // The tail vacates this move unless the snake grows, so it is not scanned.
          n_d      = eat_now ? size_q : size_q - LW'(1);
          idx_d    = '0;
          state_d  = (n_d == '0) ? S_UPDATE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          collided_d = 1'b1;
          state_d    = S_DONE;
        end else if (idx_q == n_q - LW'(1)) begin
          state_d = S_UPDATE;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      S_UPDATE: begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = cand_x_q;
        seg_y_d[0] = cand_y_q;
        last_dir_d = dir_q;
        if (eat_q && size_q < LW'(MAX_LEN)) begin
          size_d = size_q + LW'(1);
          ate_d  = 1'b1;
          if (size_q + LW'(1) == LW'(MAX_LEN)) full_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        ate_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (init) begin
      state_d = S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = init_x(i);
        seg_y_d[i] = INIT_Y;
      end
      size_d = LW'(INIT_LEN);  n_d = '0;  idx_d = '0;
      last_dir_d = DIR_RIGHT;  dir_d = DIR_RIGHT;
      cand_x_d = '0;  cand_y_d = '0;  eat_d = 1'b0;
      ate_d = 1'b0;   collided_d = 1'b0;  full_d = 1'b0;
    end
  end

  always_comb begin
    leds = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < size_q)
        leds = leds | (NC'(1) << (int'(seg_y_q[i]) * GRID_W + int'(seg_x_q[i])));
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign ate      = (state_q == S_DONE) && ate_q;
  assign collided = collided_q;
  assign full     = full_q;
  assign size     = size_q;
  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign db_state = state_q;

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake-body engine for the Snake Game Arcade (SGA) datapath. It stores the ordered segment coordinates of a snake on a GRID_W×GRID_H LED grid. On each move request it computes the new head, checks for wall and self collision over a multi-cycle scan, grows when the apple is eaten, and drives the flattened LED map. It replaces the fixed 6×6, fixed-length body logic and adds configurable grid, maximum length, wrap-around mode and reverse-direction rejection.

## Interface
- GRID_W, 6, grid columns (≥2)
- GRID_H, 6, grid rows (≥2)
- MAX_LEN, 16, maximum snake length (≥INIT_LEN+1)
- INIT_LEN, 2, length after reset/init (1..GRID_W)
- WRAP, 0, 0: leaving the grid is a collision; 1: the head wraps to the opposite edge
- XW/YW/LW: $clog2(GRID_W), $clog2(GRID_H), $clog2(MAX_LEN+1) (derived, local)

Ports:
- clock  in  1  system clock, rising edge
- restart  in  1  asynchronous, active-high reset
- init  in  1  synchronous re-initialisation, same effect as reset
- step  in  1  move request; sampled only in IDLE
- dir  in  2  00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1)
- apple_x / apple_y  in  XW / YW  apple position
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a move completes or a collision is found
- ate  out  1  one-cycle pulse coincident with done when the snake grew
- collided  out  1  sticky collision flag
- full  out  1  sticky; size reached MAX_LEN (win)
- size  out  LW  current length
- head_x / head_y  out  XW / YW  segment 0 coordinates
- leds  out  GRID_W*GRID_H  bit y*GRID_W+x set for every segment idx<size
- db_state  out  3  FSM state code

## Operation
- Reset/init values:
  - size=INIT_LEN.
  - Segment i at (INIT_LEN−1−i, GRID_H/2).
  - last_dir=right.
  - busy, done, ate, collided and full are all 0.
  - db_state=IDLE.
- FSM: IDLE(0) → HEAD(1) → SCAN(2) → UPDATE(3) → DONE(4) → IDLE.
- IDLE:
  - step=1 with collided=0 and full=0: latch dir and go to HEAD.
  - step while collided or full: ignored. No busy, no done.
- Reverse rejection: if size>1 and the latched dir is the opposite of last_dir, last_dir is used instead.
- HEAD: compute the candidate head.
  - WRAP=0 and candidate out of range: set collided, go to DONE.
  - WRAP=1: x wraps 0↔GRID_W−1 and y wraps 0↔GRID_H−1.
  - eat = (candidate == apple).
  - Set N = size−1 if eat=0, else size.
  - N=0: go to UPDATE; otherwise go to SCAN with idx=0.
- SCAN: one segment per cycle. The tail is excluded when not eating because it vacates.
  - seg[idx] == candidate: set collided, go to DONE.
  - idx == N−1 with no hit: go to UPDATE.
- UPDATE:
  - seg[i] ← seg[i−1] and seg[0] ← candidate.
  - last_dir ← the effective dir.
  - If eat and size<MAX_LEN: size+1 and ate=1 in the following DONE cycle.
  - If the new size equals MAX_LEN: full=1.
- DONE: done=1 for one cycle, then IDLE.
- leds and head are combinational from the registers. They change only at the UPDATE edge; a collision leaves them unchanged.
- Boundary rules:
  - An apple outside the grid never matches.
  - Eating at size=MAX_LEN cannot occur, because full blocks step.
  - init has priority in every state: it aborts the operation and the next cycle is IDLE with reset values and no done.

## Timing
- step sampled at edge k. busy rises after edge k.
- Normal move: HEAD 1 cycle + SCAN N cycles + UPDATE 1 cycle. done is high in cycle k+N+3 and busy falls with it.
- Wall collision: done in cycle k+2.
- Self hit at idx j: done in cycle k+j+3.
- restart is asynchronous: all outputs take reset values immediately, mid-operation included.

## Test plan
- Reset with defaults:
  - size=2, head=(1,3).
  - leds bits 18 and 19 set, all others 0.
  - busy=0.
- Step right, apple at (5,0):
  - N=1, done 4 cycles after the step edge.
  - head=(2,3), leds bits 19 and 20, size=2, ate=0.
- Apple at (3,3), step right:
  - ate=1 with done, N=2 (done at k+5).
  - size=3, leds bits 19, 20 and 21.
- Reverse rejection: last_dir right, dir=left → head moves to x+1. Wall: step right three times from head x=3.
  - WRAP=0: the third step gives collided=1 and done at k+2. leds unchanged; a further step gives no busy.
  - WRAP=1 instance: head=(0,3).
- Self collision: grow to size 5, then move up, left, down.
  - The down move hits segment idx 3, giving collided=1.
  - At size 4 the same loop chases the tail legally (no collision).
- restart pulse during SCAN: all outputs return to reset values immediately. init in SCAN: IDLE next cycle, no done pulse.
